// File: rtl/uart_reg_sched.sv
// uart_reg_sched: write-port scheduler and TX/RX sequencer for the UART
// register bank. Arbitrates one write port between RX, TX-clear and user.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   user_we_i/addr/wdata user write request (addr 0 = ctrl, 1 = data)
//   user_stall_o         user write not accepted this cycle
//   ctrl_q_i             current control register (0 send, 1 new_rx, 2 ovr)
//   rx_data_rdy_i/rx_data_i  received-byte pulse and byte
//   tx_busy_i/tx_start_o     transmitter status and start pulse
//   reg_we_ctrl_o/reg_we_data_o/reg_wdata_o  register bank write port
//   hold_ctrl_o          1 when RX/TX path owns the write port
module uart_reg_sched (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        user_we_i,
   input  logic        user_addr_i,
   input  logic [31:0] user_wdata_i,
   output logic        user_stall_o,
   input  logic [31:0] ctrl_q_i,
   input  logic        rx_data_rdy_i,
   input  logic [7:0]  rx_data_i,
   input  logic        tx_busy_i,
   output logic        tx_start_o,
   output logic        reg_we_ctrl_o,
   output logic        reg_we_data_o,
   output logic [31:0] reg_wdata_o,
   output logic        hold_ctrl_o
);

   typedef enum logic [1:0] {
      R_IDLE,
      R_DATA,
      R_FLAG
   } rx_st_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_WAIT_BUSY,
      T_WAIT_DONE,
      T_CLEAR
   } tx_st_t;

   rx_st_t      r_rx_st;
   tx_st_t      r_tx_st;
   logic [7:0]  r_rx_buf;
   logic        r_ovr;

   logic        w_rx_data_req;
   logic        w_rx_ctrl_req;
   logic        w_rx_req;
   logic        w_tx_req;
   logic        w_tx_grant;
   logic        w_user_grant;
   logic        w_start;
   logic [31:0] w_rx_ctrl;
   logic [31:0] w_tx_ctrl;

   assign w_rx_data_req = (r_rx_st == R_DATA);
   assign w_rx_ctrl_req = (r_rx_st == R_FLAG);
   assign w_rx_req      = w_rx_data_req | w_rx_ctrl_req;
   assign w_tx_req      = (r_tx_st == T_CLEAR);
   assign w_tx_grant    = w_tx_req & ~w_rx_req;
   assign w_user_grant  = user_we_i & ~w_rx_req & ~w_tx_req;
   assign w_start       = (r_tx_st == T_IDLE) & ctrl_q_i[0] & ~tx_busy_i;

   // Read-modify-write on the live register value, so RX and TX
   // control writes on consecutive cycles keep each other's bits.
   assign w_rx_ctrl = ctrl_q_i | 32'h2 | {29'b0, r_ovr, 2'b00};
   assign w_tx_ctrl = ctrl_q_i & ~32'h1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rx_st  <= R_IDLE;
         r_rx_buf <= 8'h00;
         r_ovr    <= 1'b0;
      end else begin
         unique case (r_rx_st)
            R_IDLE: begin
               if (rx_data_rdy_i) begin
                  r_rx_buf <= rx_data_i;
                  r_rx_st  <= R_DATA;
               end
            end
            R_DATA: begin
               if (rx_data_rdy_i) r_ovr <= 1'b1;
               r_rx_st <= R_FLAG;
            end
            R_FLAG: begin
               // A pulse landing on the flag write is itself an overrun.
               r_ovr   <= rx_data_rdy_i;
               r_rx_st <= R_IDLE;
            end
            default: r_rx_st <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tx_st <= T_IDLE;
      end else begin
         unique case (r_tx_st)
            T_IDLE: begin
               if (w_start) r_tx_st <= T_WAIT_BUSY;
            end
            T_WAIT_BUSY: begin
               if (tx_busy_i) r_tx_st <= T_WAIT_DONE;
            end
            T_WAIT_DONE: begin
               if (!tx_busy_i) r_tx_st <= T_CLEAR;
            end
            T_CLEAR: begin
               if (!w_rx_req) r_tx_st <= T_IDLE;
            end
            default: r_tx_st <= T_IDLE;
         endcase
      end
   end

   // Outputs are forced low while reset is held, including the paths
   // that would otherwise pass user/ctrl inputs straight through.
   always_comb begin
      reg_we_ctrl_o = 1'b0;
      reg_we_data_o = 1'b0;
      reg_wdata_o   = 32'h0;
      hold_ctrl_o   = 1'b0;
      user_stall_o  = 1'b0;
      tx_start_o    = 1'b0;
      if (rst_ni) begin
         hold_ctrl_o  = w_rx_req | w_tx_req;
         user_stall_o = user_we_i & (w_rx_req | w_tx_req);
         tx_start_o   = w_start;
         unique case (1'b1)
            w_rx_data_req: begin
               reg_we_data_o = 1'b1;
               reg_wdata_o   = {24'b0, r_rx_buf};
            end
            w_rx_ctrl_req: begin
               reg_we_ctrl_o = 1'b1;
               reg_wdata_o   = w_rx_ctrl;
            end
            w_tx_grant: begin
               reg_we_ctrl_o = 1'b1;
               reg_wdata_o   = w_tx_ctrl;
            end
            w_user_grant: begin
               reg_we_ctrl_o = ~user_addr_i;
               reg_we_data_o = user_addr_i;
               reg_wdata_o   = user_wdata_i;
            end
            default: begin
               reg_we_ctrl_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_reg_sched.sv
// tb_uart_reg_sched: directed bench with a cycle-tagged write scoreboard.
// Expected writes are queued when stimulus is driven, popped when due.
module tb_uart_reg_sched;

   logic        clk;
   logic        rst_ni;
   logic        user_we_i;
   logic        user_addr_i;
   logic [31:0] user_wdata_i;
   logic        user_stall_o;
   logic [31:0] ctrl_q_i;
   logic        rx_data_rdy_i;
   logic [7:0]  rx_data_i;
   logic        tx_busy_i;
   logic        tx_start_o;
   logic        reg_we_ctrl_o;
   logic        reg_we_data_o;
   logic [31:0] reg_wdata_o;
   logic        hold_ctrl_o;

   typedef struct packed {
      int unsigned due;
      logic        c;
      logic        d;
      logic [31:0] w;
      logic        h;
   } ent_t;

   ent_t        sb[$];
   int unsigned cyc;
   int          total;
   int          bad;

   uart_reg_sched dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .user_we_i    (user_we_i),
      .user_addr_i  (user_addr_i),
      .user_wdata_i (user_wdata_i),
      .user_stall_o (user_stall_o),
      .ctrl_q_i     (ctrl_q_i),
      .rx_data_rdy_i(rx_data_rdy_i),
      .rx_data_i    (rx_data_i),
      .tx_busy_i    (tx_busy_i),
      .tx_start_o   (tx_start_o),
      .reg_we_ctrl_o(reg_we_ctrl_o),
      .reg_we_data_o(reg_we_data_o),
      .reg_wdata_o  (reg_wdata_o),
      .hold_ctrl_o  (hold_ctrl_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [39:0] o,
                      input logic [39:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic push(input int unsigned due, input logic c,
                       input logic d, input logic [31:0] w,
                       input logic h);
      ent_t x;
      x.due = due;
      x.c   = c;
      x.d   = d;
      x.w   = w;
      x.h   = h;
      sb.push_back(x);
   endtask

   task automatic eval();
      ent_t x;
      #1;
      chk("one_we", 40'(reg_we_ctrl_o & reg_we_data_o), 40'h0);
      if (sb.size() > 0 && sb[0].due == cyc) begin
         x = sb.pop_front();
         chk($sformatf("wr@%0d", cyc),
             40'({reg_we_ctrl_o, reg_we_data_o, reg_wdata_o, hold_ctrl_o}),
             40'({x.c, x.d, x.w, x.h}));
      end else begin
         chk($sformatf("nowr@%0d", cyc),
             40'({reg_we_ctrl_o, reg_we_data_o, hold_ctrl_o}), 40'h0);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      eval();
      adv();
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, 40'({user_stall_o, tx_start_o, reg_we_ctrl_o,
                    reg_we_data_o, reg_wdata_o, hold_ctrl_o}), 40'h0);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      cyc           = 0;
      rst_ni        = 1'b0;
      user_we_i     = 1'b0;
      user_addr_i   = 1'b0;
      user_wdata_i  = 32'h0;
      ctrl_q_i      = 32'h0;
      rx_data_rdy_i = 1'b0;
      rx_data_i     = 8'h00;
      tx_busy_i     = 1'b0;
      #3;
      chk_zero("rst_out");
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      step();
      step();

      // user path on an idle system
      user_we_i    = 1'b1;
      user_addr_i  = 1'b1;
      user_wdata_i = 32'h55;
      push(cyc, 1'b0, 1'b1, 32'h55, 1'b0);
      eval();
      chk("user_stall0", 40'(user_stall_o), 40'h0);
      adv();
      user_we_i = 1'b0;
      step();

      // basic RX
      rx_data_rdy_i = 1'b1;
      rx_data_i     = 8'hA5;
      push(cyc + 1, 1'b0, 1'b1, 32'h000000A5, 1'b1);
      push(cyc + 2, 1'b1, 1'b0, 32'h2, 1'b1);
      step();
      rx_data_rdy_i = 1'b0;
      repeat (3) step();

      // overrun: second pulse while in R_DATA is dropped
      rx_data_rdy_i = 1'b1;
      rx_data_i     = 8'h11;
      push(cyc + 1, 1'b0, 1'b1, 32'h11, 1'b1);
      push(cyc + 2, 1'b1, 1'b0, 32'h6, 1'b1);
      step();
      rx_data_i = 8'h22;
      step();
      rx_data_rdy_i = 1'b0;
      repeat (2) step();
      rx_data_rdy_i = 1'b1;
      rx_data_i     = 8'h33;
      push(cyc + 1, 1'b0, 1'b1, 32'h33, 1'b1);
      push(cyc + 2, 1'b1, 1'b0, 32'h2, 1'b1);
      step();
      rx_data_rdy_i = 1'b0;
      repeat (3) step();

      // TX sequence
      ctrl_q_i = 32'h1;
      eval();
      chk("tx_start1", 40'(tx_start_o), 40'h1);
      adv();
      eval();
      chk("tx_start_pulse", 40'(tx_start_o), 40'h0);
      adv();
      tx_busy_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         eval();
         chk("tx_nostart", 40'(tx_start_o), 40'h0);
         adv();
      end
      tx_busy_i = 1'b0;
      push(cyc + 1, 1'b1, 1'b0, 32'h0, 1'b1);
      step();
      step();
      ctrl_q_i = 32'h0;
      eval();
      chk("tx_idle", 40'(tx_start_o), 40'h0);
      adv();
      step();

      // collision: TX clear vs RX data vs user write
      ctrl_q_i = 32'hF1;
      eval();
      chk("col_start", 40'(tx_start_o), 40'h1);
      adv();
      tx_busy_i = 1'b1;
      repeat (3) step();
      tx_busy_i     = 1'b0;
      rx_data_rdy_i = 1'b1;
      rx_data_i     = 8'h5A;
      push(cyc + 1, 1'b0, 1'b1, 32'h5A, 1'b1);
      push(cyc + 2, 1'b1, 1'b0, 32'hF3, 1'b1);
      push(cyc + 3, 1'b1, 1'b0, 32'hF2, 1'b1);
      step();
      rx_data_rdy_i = 1'b0;
      user_we_i     = 1'b1;
      user_addr_i   = 1'b0;
      user_wdata_i  = 32'h76;
      push(cyc + 3, 1'b1, 1'b0, 32'h76, 1'b0);
      eval();
      chk("col_stall0", 40'(user_stall_o), 40'h1);
      adv();
      eval();
      chk("col_stall1", 40'(user_stall_o), 40'h1);
      adv();
      ctrl_q_i = 32'hF3;
      eval();
      chk("col_stall2", 40'(user_stall_o), 40'h1);
      adv();
      ctrl_q_i = 32'hF2;
      eval();
      chk("col_stall3", 40'(user_stall_o), 40'h0);
      adv();
      ctrl_q_i  = 32'h76;
      user_we_i = 1'b0;
      repeat (3) step();

      // reset asserted while RX is in R_DATA
      rx_data_rdy_i = 1'b1;
      rx_data_i     = 8'hC3;
      push(cyc + 1, 1'b0, 1'b1, 32'hC3, 1'b1);
      step();
      rx_data_rdy_i = 1'b0;
      eval();
      #1;
      rst_ni       = 1'b0;
      user_we_i    = 1'b1;
      user_addr_i  = 1'b1;
      user_wdata_i = 32'h9;
      ctrl_q_i     = 32'h1;
      #1;
      chk_zero("rst_mid");
      adv();
      eval();
      chk_zero("rst_hold");
      adv();
      user_we_i = 1'b0;
      ctrl_q_i  = 32'h0;
      rst_ni    = 1'b1;
      repeat (4) step();

      chk("sb_empty", 40'(sb.size()), 40'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
